// File: rtl/pram_access_arbiter_pkg.sv
// tau_mem_pkg: shared types for the program-RAM access path.
// Contents: owner_t read-response owner tag, RW_READ/RW_WRITE encodings and
// the starve counter width helper used by arb_starve_counter.
package tau_mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LS    = 2'd2
  } owner_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // The counter is at least 3 bits and is always wide enough to hold the limit.
  function automatic int unsigned starve_cnt_width(input int unsigned limit);
    int unsigned w;
    w = $clog2(limit + 1);
    return (w < 3) ? 3 : w;
  endfunction

endpackage

// File: rtl/pram_access_arbiter_starve.sv
// arb_starve_counter: counts consecutive cycles in which fetch is requesting but not granted.
// Ports: clock/reset (sync, active-high), fetch_req_i, fetch_grant_i in; force_fetch_o out
//        (high once the count reaches STARVE_LIMIT, so fetch wins the next contested cycle).
module arb_starve_counter
  import tau_mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic fetch_req_i,
  input  logic fetch_grant_i,
  output logic force_fetch_o
);

  localparam int unsigned CW = starve_cnt_width(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!fetch_req_i || fetch_grant_i) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Counter is registered, so forcing fetch never feeds back combinationally
  // into the grant that drives this counter.
  assign force_fetch_o = (cnt_q == LIMIT);

endmodule

// File: rtl/pram_access_arbiter.sv
// pram_access_arbiter: shares the single-port sync program RAM between instruction fetch and
// load/store. One grant per cycle (ls > fetch), read data returned 1 cycle later with a valid strobe.
// Ports: clock, reset (sync, high); fetch_req/addr in, fetch_grant/rdata/rvalid out;
//        ls_req/rw/addr/wdata in, ls_grant/rdata/rvalid out; ram_enable/rw/address/data_in out,
//        ram_data_out in. Optional macro PRAM_ARB_STARVE_GUARD_EN adds the fetch anti-starvation guard.
module pram_access_arbiter
  import tau_mem_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     fetch_req,
  input  logic [ADDRESS_WIDTH-1:0] fetch_addr,
  output logic                     fetch_grant,
  output logic [DATA_WIDTH-1:0]    fetch_rdata,
  output logic                     fetch_rvalid,
  input  logic                     ls_req,
  input  logic                     ls_rw,
  input  logic [ADDRESS_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0]    ls_wdata,
  output logic                     ls_grant,
  output logic [DATA_WIDTH-1:0]    ls_rdata,
  output logic                     ls_rvalid,
  output logic                     ram_enable,
  output logic                     ram_rw,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0]    ram_data_in,
  input  logic [DATA_WIDTH-1:0]    ram_data_out
);

  owner_t owner_q;
  owner_t owner_d;
  logic   force_fetch;

`ifdef PRAM_ARB_STARVE_GUARD_EN
  arb_starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clock         (clock),
    .reset         (reset),
    .fetch_req_i   (fetch_req),
    .fetch_grant_i (fetch_grant),
    .force_fetch_o (force_fetch)
  );
`else
  assign force_fetch = 1'b0;
`endif

  // Arbitration. Everything is gated by reset so nothing reaches the RAM
  // while reset is held, even with requests pending.
  always_comb begin
    fetch_grant = 1'b0;
    ls_grant    = 1'b0;
    ram_enable  = 1'b0;
    ram_rw      = RW_READ;
    ram_address = '0;
    ram_data_in = '0;
    owner_d     = OWN_NONE;
    if (!reset) begin
      if (ls_req && !(force_fetch && fetch_req)) begin
        ls_grant    = 1'b1;
        ram_enable  = 1'b1;
        ram_rw      = ls_rw;
        ram_address = ls_addr;
        ram_data_in = ls_wdata;
        // Writes complete on grant; only reads get a response slot.
        owner_d     = (ls_rw == RW_READ) ? OWN_LS : OWN_NONE;
      end else if (fetch_req) begin
        fetch_grant = 1'b1;
        ram_enable  = 1'b1;
        ram_rw      = RW_READ;
        ram_address = fetch_addr;
        owner_d     = OWN_FETCH;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // A response due in a reset cycle belongs to an access issued before
  // reset, so it is suppressed rather than delivered.
  assign fetch_rvalid = !reset && (owner_q == OWN_FETCH);
  assign ls_rvalid    = !reset && (owner_q == OWN_LS);
  assign fetch_rdata  = ram_data_out;
  assign ls_rdata     = ram_data_out;

endmodule

// File: tb/tb_pram_access_arbiter.sv
module tb_pram_access_arbiter;

  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int LIMIT = 4;
`ifdef PRAM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_grant;
  logic [DW-1:0] fetch_rdata;
  logic          fetch_rvalid;
  logic          ls_req;
  logic          ls_rw;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          ls_grant;
  logic [DW-1:0] ls_rdata;
  logic          ls_rvalid;
  logic          ram_enable;
  logic          ram_rw;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out = '0;

  always #5 clock = ~clock;

  pram_access_arbiter #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .STARVE_LIMIT  (LIMIT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_grant  (fetch_grant),
    .fetch_rdata  (fetch_rdata),
    .fetch_rvalid (fetch_rvalid),
    .ls_req       (ls_req),
    .ls_rw        (ls_rw),
    .ls_addr      (ls_addr),
    .ls_wdata     (ls_wdata),
    .ls_grant     (ls_grant),
    .ls_rdata     (ls_rdata),
    .ls_rvalid    (ls_rvalid),
    .ram_enable   (ram_enable),
    .ram_rw       (ram_rw),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  // Environment: single-port synchronous RAM, 256 words, preloaded from init_word.
  function automatic logic [DW-1:0] init_word(input int i);
    logic [DW-1:0] w;
    w = 16'(i * 947) ^ 16'h5a5a;
    if (i == 4) w = 16'hA1B2;
    return w;
  endfunction

  logic          preload;
  logic [DW-1:0] ram [0:255];

  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
    end else if (ram_enable) begin
      if (ram_rw) ram[ram_address[7:0]] <= ram_data_in;
      else        ram_data_out <= ram[ram_address[7:0]];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a word array for memory contents, the kind/data of the one
  // response due next cycle, and how many cycles fetch has waited in a row.
  logic [DW-1:0] ref_mem [0:255];
  int            pend, pend_n;          // 0 none, 1 fetch, 2 ls
  logic [DW-1:0] pend_data, pend_data_n;
  int            wait_cnt, wait_n;
  bit            wr_n;
  logic [7:0]    wr_a;
  logic [DW-1:0] wr_d;
  bit            m_ls_win, m_f_win;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    pend = 0; pend_n = 0; wait_cnt = 0; wait_n = 0; wr_n = 0;
    pend_data = '0; pend_data_n = '0; wr_a = '0; wr_d = '0;
    forever begin
      @(negedge clock);
      if (wr_n) ref_mem[wr_a] = wr_d;
      pend      = pend_n;
      pend_data = pend_data_n;
      wait_cnt  = wait_n;

      m_ls_win = !reset && ls_req && !(GUARD && fetch_req && wait_cnt >= LIMIT);
      m_f_win  = !reset && fetch_req && !m_ls_win;

      chk("fetch_grant", fetch_grant, m_f_win);
      chk("ls_grant", ls_grant, m_ls_win);
      chk("ram_enable", ram_enable, m_ls_win || m_f_win);
      if (m_ls_win) begin
        chk("ram_rw_ls", ram_rw, ls_rw);
        chk("ram_addr_ls", ram_address, ls_addr);
        if (ls_rw) chk("ram_wdata", ram_data_in, ls_wdata);
      end else if (m_f_win) begin
        chk("ram_rw_f", ram_rw, 0);
        chk("ram_addr_f", ram_address, fetch_addr);
      end else begin
        chk("ram_rw_idle", ram_rw, 0);
        if (reset) begin
          chk("ram_addr_rst", ram_address, 0);
          chk("ram_din_rst", ram_data_in, 0);
        end
      end
      chk("fetch_rvalid", fetch_rvalid, !reset && pend == 1);
      chk("ls_rvalid", ls_rvalid, !reset && pend == 2);
      if (!reset && pend == 1) chk("fetch_rdata", fetch_rdata, pend_data);
      if (!reset && pend == 2) chk("ls_rdata", ls_rdata, pend_data);

      wr_n = m_ls_win && ls_rw;
      wr_a = ls_addr[7:0];
      wr_d = ls_wdata;
      pend_n = m_f_win ? 1 : ((m_ls_win && !ls_rw) ? 2 : 0);
      pend_data_n = m_f_win ? ref_mem[fetch_addr[7:0]] : ref_mem[ls_addr[7:0]];
      wait_n = (reset || !fetch_req || m_f_win) ? 0 :
               ((wait_cnt < LIMIT) ? wait_cnt + 1 : LIMIT);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  int         fgr, fidx;
  logic [1:0] rv;
  bit         gf, gl;

  initial begin
    reset = 1'b1; preload = 1'b1;
    fetch_req = 1'b1; fetch_addr = 16'h0030;
    ls_req = 1'b1; ls_rw = 1'b0; ls_addr = 16'h0020; ls_wdata = '0;

    // 1: reset held 3 cycles with both requesting
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("t1_rst_fgrant", fetch_grant, 0);
      chk("t1_rst_lgrant", ls_grant, 0);
      chk("t1_rst_enable", ram_enable, 0);
      chk("t1_rst_rvalid", {fetch_rvalid, ls_rvalid}, 0);
      step();
      preload = 1'b0;
    end
    reset = 1'b0;
    @(negedge clock);
    chk("t1_ls_grant", ls_grant, 1);
    step();
    ls_req = 1'b0;                      // fetch still pending, wins now
    step();
    fetch_addr = 16'h0004;              // 2: new fetch to word 0xA1B2
    @(negedge clock);
    chk("t2_grant", fetch_grant, 1);
    step();
    fetch_req = 1'b0;
    @(negedge clock);
    chk("t2_rvalid", fetch_rvalid, 1);
    chk("t2_rdata", fetch_rdata, 16'hA1B2);

    // 3: write then immediate read of the same address
    step();
    ls_req = 1'b1; ls_rw = 1'b1; ls_addr = 16'h0010; ls_wdata = 16'hBEEF;
    @(negedge clock);
    chk("t3_wgrant", ls_grant, 1);
    step();
    ls_rw = 1'b0;
    @(negedge clock);
    chk("t3_no_rvalid", ls_rvalid, 0);
    chk("t3_rgrant", ls_grant, 1);
    step();
    ls_req = 1'b0;
    @(negedge clock);
    chk("t3_rvalid", ls_rvalid, 1);
    chk("t3_rdata", ls_rdata, 16'hBEEF);

    // 4: contested read stream for 6 cycles
    step();
    fetch_req = 1'b1; fetch_addr = 16'h0008;
    ls_req = 1'b1; ls_rw = 1'b0; ls_addr = 16'h0040;
    fgr = 0; fidx = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      if (fetch_grant) begin fgr++; fidx = k; end
      gl = ls_grant;
      step();
      if (gl) ls_addr = 16'($urandom_range(0, 255));
    end
    fetch_req = 1'b0; ls_req = 1'b0;
    chk("t4_fetch_grants", fgr, GUARD ? 1 : 0);
    chk("t4_fetch_cycle", fidx, GUARD ? 5 : 0);

    // 5: fetch, ls read, fetch back to back
    fetch_req = 1'b1; fetch_addr = 16'h0001;
    step();
    fetch_req = 1'b0; ls_req = 1'b1; ls_rw = 1'b0; ls_addr = 16'h0002;
    @(negedge clock); rv = {fetch_rvalid, ls_rvalid};
    chk("t5_rv_n1", rv, 2'b10);
    step();
    ls_req = 1'b0; fetch_req = 1'b1; fetch_addr = 16'h0003;
    @(negedge clock); rv = {fetch_rvalid, ls_rvalid};
    chk("t5_rv_n2", rv, 2'b01);
    step();
    fetch_req = 1'b0;
    @(negedge clock); rv = {fetch_rvalid, ls_rvalid};
    chk("t5_rv_n3", rv, 2'b10);

    // 6: reset right after a granted read drops its response
    step();
    fetch_req = 1'b1; fetch_addr = 16'h0005;
    @(negedge clock);
    chk("t6_grant", fetch_grant, 1);
    step();
    fetch_req = 1'b0; reset = 1'b1;
    @(negedge clock);
    chk("t6_rv_n1", {fetch_rvalid, ls_rvalid}, 0);
    step();
    reset = 1'b0;
    @(negedge clock);
    chk("t6_rv_n2", {fetch_rvalid, ls_rvalid}, 0);

    // Random traffic; each requester holds its request until granted.
    step();
    for (int k = 0; k < 600; k++) begin
      @(negedge clock);
      gf = fetch_grant; gl = ls_grant;
      step();
      if (!fetch_req || gf) begin
        fetch_req  = ($urandom_range(0, 3) != 0);
        fetch_addr = 16'($urandom_range(0, 31));
      end
      if (!ls_req || gl) begin
        ls_req   = ($urandom_range(0, 1) == 1);
        ls_rw    = ($urandom_range(0, 2) == 0);
        ls_addr  = 16'($urandom_range(0, 31));
        ls_wdata = 16'($urandom);
      end
    end
    fetch_req = 1'b0; ls_req = 1'b0;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
